// File: rtl/dse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dse_pkg
// Description : Shared definitions for the DSE output path: record magic
//               numbers, magic field width and the scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dse_pkg;

    localparam int MAGIC_W = 8;

    localparam logic [MAGIC_W-1:0] MAGIC_EMULATE = 8'd1;
    localparam logic [MAGIC_W-1:0] MAGIC_DEG     = 8'd2;
    localparam logic [MAGIC_W-1:0] MAGIC_DEGDONE = 8'd3;
    localparam logic [MAGIC_W-1:0] MAGIC_FINISH  = 8'd4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dse_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dse_rec_fifo
// Description : Circular record buffer with extended pointers for full/empty
//               disambiguation. Flush discards every queued record and wins
//               over a coincident push. Admission decisions live in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module dse_rec_fifo #(
    parameter int REC_W = 264,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [REC_W-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [REC_W-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [REC_W-1:0]   r_mem [DEPTH];

    // Pointer update; flush collapses the read pointer onto the write pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Record storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clock) begin
        if (push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

    assign count = r_wr_ptr - r_rd_ptr;
    assign head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/dse_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dse_out_scheduler
// Description : Buffers tagged DSE records and serializes each into BEAT_W
//               beats (LSB first) on a valid/ready stream. The last FIFO slot
//               is held back for the finish record; refused records are
//               counted in a saturating drop counter with a sticky flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dse_out_scheduler #(
    parameter int REC_W   = 264,
    parameter int MAGIC_W = 8,
    parameter int BEAT_W  = 64,
    parameter int DEPTH   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_enable,
    input  logic [REC_W-1:0]    in_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BEAT_W-1:0]   out_data,
    output logic                out_last,
    output logic                drained,
    output logic [31:0]         drop_cnt,
    output logic                overflow
);

    import dse_pkg::*;

    localparam int NBEATS  = (REC_W + BEAT_W - 1) / BEAT_W;
    localparam int SHIFT_W = NBEATS * BEAT_W;
    localparam int IDX_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NBEATS - 1);
    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_reserve  = CNT_W'(DEPTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [SHIFT_W-1:0]   r_shift;
    logic [SHIFT_W-1:0]   w_head_ext;
    logic [CNT_W-1:0]     w_count;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [REC_W-1:0]     w_head;
    logic [MAGIC_W-1:0]   w_magic;
    logic                 w_empty;
    logic                 w_admit;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_advance;
    logic                 r_drained;
    logic [31:0]          r_drop_cnt;
    logic                 r_overflow;

    dse_rec_fifo #(
        .REC_W (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .flush     (flush),
        .count     (w_count),
        .head      (w_head)
    );

    // Admission against the start-of-cycle count; regular records may not
    // take the final slot, which stays free for the finish record
    assign w_magic = in_data[REC_W-1 -: MAGIC_W];
    assign w_empty = (w_count == '0);
    assign w_admit = (w_magic == MAGIC_W'(MAGIC_FINISH)) ? (w_count < c_depth)
                                                         : (w_count < c_reserve);
    assign w_push  = in_enable && !flush && w_admit;
    assign w_drop  = in_enable && !flush && !w_admit;

    assign w_count_nxt = flush ? '0 : (w_count + CNT_W'(w_push) - CNT_W'(w_pop));

    // Zero-extend the head record so the final beat carries zeros above REC_W
    always_comb begin
        w_head_ext              = '0;
        w_head_ext[REC_W-1:0]   = w_head;
    end

    // Serializer next-state, pop and beat-advance decisions
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (r_idx != c_last_idx) begin
                        w_advance = 1'b1;
                    end else if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Shift register and beat index; cleared on return to idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift <= '0;
            r_idx   <= '0;
        end else if (w_pop) begin
            r_shift <= w_head_ext;
            r_idx   <= '0;
        end else if (w_advance) begin
            r_shift <= r_shift >> BEAT_W;
            r_idx   <= r_idx + IDX_W'(1);
        end else if ((r_state == SEND) && (w_state_nxt == IDLE)) begin
            r_shift <= '0;
            r_idx   <= '0;
        end
    end

    // Drained flag registered from next-cycle state and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_drained <= 1'b1;
        else       r_drained <= (w_state_nxt == IDLE) && (w_count_nxt == '0);
    end

    // Saturating drop counter and sticky overflow flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign out_valid = (r_state == SEND);
    assign out_last  = (r_state == SEND) && (r_idx == c_last_idx);
    assign out_data  = r_shift[BEAT_W-1:0];
    assign drained   = r_drained;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dse_out_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dse_out_scheduler
// Description : Directed self-checking bench for dse_out_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dse_out_scheduler;

    logic          clock;
    logic          reset;
    logic          in_enable;
    logic [263:0]  in_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   out_data;
    logic          out_last;
    logic          drained;
    logic [31:0]   drop_cnt;
    logic          overflow;

    int n_assert = 0;
    int n_fail   = 0;
    logic [263:0] exp_q[$];

    dse_out_scheduler #(
        .REC_W   (264),
        .MAGIC_W (8),
        .BEAT_W  (64),
        .DEPTH   (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_enable (in_enable),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .drained   (drained),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record: 32 payload bytes counting up from seed, magic in the top byte
    function automatic logic [263:0] make_rec(input logic [7:0] magic, input logic [7:0] seed);
        logic [263:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k*8 +: 8] = seed + 8'(k);
        r[263:256] = magic;
        return r;
    endfunction

    // Presents one record for a single clock; starts and ends at a negedge
    task automatic drive_rec(input logic [263:0] rec);
        in_enable = 1'b1;
        in_data   = rec;
        @(negedge clock);
        in_enable = 1'b0;
        in_data   = '0;
    endtask

    // Drains exp_q with out_ready held high, checking every beat
    task automatic collect(input bit no_gap, input int budget, output int n_beats);
        int beat;
        int cyc;
        bit started;
        logic [319:0] ext;
        beat = 0; cyc = 0; started = 0; n_beats = 0;
        out_ready = 1'b1;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (no_gap && started) begin
                n_assert++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_gap cycle=%0d got out_valid=%b exp=1", cyc, out_valid);
                end
            end
            if (out_valid === 1'b1) begin
                started = 1;
                ext = {56'h0, exp_q[0]};
                n_assert++;
                if (out_data !== ext[beat*64 +: 64]) begin
                    n_fail++;
                    $display("FAIL collect_data beat=%0d got=%h exp=%h", beat, out_data, ext[beat*64 +: 64]);
                end
                n_assert++;
                if (out_last !== (beat == 4)) begin
                    n_fail++;
                    $display("FAIL collect_last beat=%0d got=%b exp=%b", beat, out_last, (beat == 4));
                end
                n_beats++;
                if (beat == 4) begin
                    beat = 0;
                    void'(exp_q.pop_front());
                end else begin
                    beat++;
                end
            end
            @(negedge clock);
            cyc++;
        end
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL collect_timeout got records_left=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_enable = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_assert++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", out_last); end
        n_assert++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL reset_drained got=%b exp=1", drained); end
        n_assert++; if (drop_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        reset = 1'b0;
        @(negedge clock);
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL post_reset_drained got=%b exp=1", drained); end
    endtask

    task automatic test_single();
        logic [63:0] eb [5];
        eb[0] = 64'h0706050403020100;
        eb[1] = 64'h0f0e0d0c0b0a0908;
        eb[2] = 64'h1716151413121110;
        eb[3] = 64'h1f1e1d1c1b1a1918;
        eb[4] = 64'h0000000000000002;
        out_ready = 1'b1;
        drive_rec(make_rec(8'd2, 8'h00));
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_delay got=%b exp=0", out_valid); end
        n_assert++; if (drained !== 1'b0) begin n_fail++; $display("FAIL single_drained_low got=%b exp=0", drained); end
        @(negedge clock);
        for (int b = 0; b < 5; b++) begin
            n_assert++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid beat=%0d got=%b exp=1", b, out_valid); end
            n_assert++; if (out_data !== eb[b]) begin n_fail++; $display("FAIL single_data beat=%0d got=%h exp=%h", b, out_data, eb[b]); end
            n_assert++; if (out_last !== (b == 4)) begin n_fail++; $display("FAIL single_last beat=%0d got=%b exp=%b", b, out_last, (b == 4)); end
            @(negedge clock);
        end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", out_valid); end
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL single_drained got=%b exp=1", drained); end
    endtask

    task automatic test_backpressure();
        logic [263:0] rec;
        logic [319:0] ext;
        logic [3:0]   pat;
        int hs;
        int cyc;
        pat = 4'b1001;
        out_ready = 1'b0;
        rec = make_rec(8'd2, 8'h40);
        ext = {56'h0, rec};
        drive_rec(rec);
        hs = 0; cyc = 0;
        while (hs < 5 && cyc < 60) begin
            out_ready = pat[cyc % 4];
            if (out_valid === 1'b1) begin
                n_assert++;
                if (out_data !== ext[hs*64 +: 64]) begin
                    n_fail++; $display("FAIL bp_data beat=%0d got=%h exp=%h", hs, out_data, ext[hs*64 +: 64]);
                end
                n_assert++;
                if (out_last !== (hs == 4)) begin
                    n_fail++; $display("FAIL bp_last beat=%0d got=%b exp=%b", hs, out_last, (hs == 4));
                end
                if (out_ready) hs++;
            end
            @(negedge clock);
            cyc++;
        end
        out_ready = 1'b0;
        n_assert++; if (hs != 5) begin n_fail++; $display("FAIL bp_handshakes got=%0d exp=5", hs); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", out_valid); end
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL bp_drained got=%b exp=1", drained); end
    endtask

    task automatic test_overflow();
        logic [263:0] r;
        int nb;
        out_ready = 1'b0;
        // A stalled record already occupies the serializer so that the FIFO
        // alone has to absorb the burst that follows.
        r = make_rec(8'd1, 8'hA0);
        exp_q.push_back(r);
        drive_rec(r);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            r = make_rec(8'd2, 8'(i * 16));
            if (i < 7) exp_q.push_back(r);
            drive_rec(r);
        end
        r = make_rec(8'd4, 8'hF0);
        exp_q.push_back(r);
        drive_rec(r);
        n_assert++; if (drop_cnt !== 32'd3) begin n_fail++; $display("FAIL ovf_drop_cnt got=%0d exp=3", drop_cnt); end
        n_assert++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_assert++; if (drained !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got=%b exp=0", drained); end
        // FIFO now holds DEPTH records: even a finish record is refused
        drive_rec(make_rec(8'd4, 8'hE0));
        n_assert++; if (drop_cnt !== 32'd4) begin n_fail++; $display("FAIL ovf_full_finish got=%0d exp=4", drop_cnt); end
        collect(1'b1, 100, nb);
        n_assert++; if (nb != 45) begin n_fail++; $display("FAIL ovf_beats got=%0d exp=45", nb); end
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL ovf_end_drained got=%b exp=1", drained); end
    endtask

    task automatic test_back_to_back();
        logic [263:0] r;
        int nb;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            r = make_rec(8'(3 - i), 8'(8'h11 * (i + 1)));
            exp_q.push_back(r);
            drive_rec(r);
        end
        @(negedge clock);
        collect(1'b1, 60, nb);
        n_assert++; if (nb != 15) begin n_fail++; $display("FAIL b2b_beats got=%0d exp=15", nb); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        logic [263:0] r0;
        logic [319:0] ext;
        int beat;
        int cyc;
        int seen;
        out_ready = 1'b0;
        r0 = make_rec(8'd2, 8'h50);
        ext = {56'h0, r0};
        drive_rec(r0);
        for (int i = 1; i < 4; i++) drive_rec(make_rec(8'd2, 8'(8'h50 + 8'(i * 32))));
        @(negedge clock);
        out_ready = 1'b1;
        beat = 0; cyc = 0;
        while (beat < 5 && cyc < 40) begin
            if (out_valid === 1'b1) begin
                n_assert++;
                if (out_data !== ext[beat*64 +: 64]) begin
                    n_fail++; $display("FAIL flush_data beat=%0d got=%h exp=%h", beat, out_data, ext[beat*64 +: 64]);
                end
                if (beat == 2) begin
                    flush = 1'b1;
                    in_enable = 1'b1;
                    in_data = make_rec(8'd2, 8'h99);
                end
                beat++;
            end
            @(negedge clock);
            flush = 1'b0;
            in_enable = 1'b0;
            in_data = '0;
            cyc++;
        end
        n_assert++; if (beat != 5) begin n_fail++; $display("FAIL flush_rec0_beats got=%0d exp=5", beat); end
        n_assert++; if (drained !== 1'b1) begin n_fail++; $display("FAIL flush_drained got=%b exp=1", drained); end
        seen = 0;
        repeat (8) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clock);
        end
        n_assert++; if (seen != 0) begin n_fail++; $display("FAIL flush_residue got=%0d valid_cycles exp=0", seen); end
        n_assert++; if (drop_cnt !== 32'd4) begin n_fail++; $display("FAIL flush_drop_cnt got=%0d exp=4", drop_cnt); end
    endtask

    task automatic test_async_reset();
        logic [263:0] rec;
        logic [319:0] ext;
        int cyc;
        int seen;
        int nb;
        out_ready = 1'b0;
        rec = make_rec(8'd2, 8'h70);
        ext = {56'h0, rec};
        drive_rec(rec);
        @(negedge clock);
        out_ready = 1'b1;
        cyc = 0;
        while (out_data !== ext[3*64 +: 64] && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        n_assert++; if (cyc >= 20) begin n_fail++; $display("FAIL arst_reach_beat3 got=%0d cycles exp<20", cyc); end
        #2 reset = 1'b1;
        #1;
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
        n_assert++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL arst_data got=%h exp=0", out_data); end
        n_assert++; if (drop_cnt !== 32'h0) begin n_fail++; $display("FAIL arst_drop_cnt got=%0d exp=0", drop_cnt); end
        n_assert++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL arst_overflow got=%b exp=0", overflow); end
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clock);
        end
        n_assert++; if (seen != 0) begin n_fail++; $display("FAIL arst_partial got=%0d valid_cycles exp=0", seen); end
        rec = make_rec(8'd3, 8'hC0);
        exp_q.push_back(rec);
        drive_rec(rec);
        collect(1'b0, 40, nb);
        n_assert++; if (nb != 5) begin n_fail++; $display("FAIL arst_new_beats got=%0d exp=5", nb); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/dse_out_scheduler.md
Name: dse_out_scheduler

Overview:
- Sits between the DSE endpoint's tagged record output (magic number + payload, single-cycle enable, no backpressure) and the narrow host-side DMA/bridge stream.
- Buffers records in a small FIFO and serializes each wide record into fixed-width beats over a valid/ready stream.
- Reserves capacity so the finish record (magic 4) is never lost.
- Counts dropped records so the host driver can detect lost DEG data.

Parameters:
- REC_W, 264, record width (payload + magic); magic occupies the top MAGIC_W bits.
- MAGIC_W, 8, magic number field width.
- BEAT_W, 64, output beat width.
- DEPTH, 8, FIFO depth in records; power of two, minimum 4.
- NBEATS, derived, ceil(REC_W/BEAT_W); 5 at defaults.

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- in_enable  in  1  record valid this cycle (endpoint out_enable)
- in_data  in  REC_W  record (endpoint out_data)
- flush  in  1  synchronous: discard all queued records not yet popped
- out_valid  out  1  beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  BEAT_W  current beat
- out_last  out  1  final beat of a record
- drained  out  1  FIFO empty and serializer idle
- drop_cnt  out  32  records dropped, saturating
- overflow  out  1  sticky: at least one drop since reset

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty; state IDLE; beat index 0.
  - out_valid=0, out_last=0, out_data=0, drained=1, drop_cnt=0, overflow=0.
  - Reset mid-record abandons the record; no partial beats follow.
- Admission uses the FIFO count at the start of the cycle. A pop in the same cycle does not free space for that cycle's push.
  - magic==4 (finish): accepted if count<DEPTH.
  - Any other magic: accepted if count<DEPTH-1. The last slot is reserved for finish.
  - Rejected record: drop_cnt increments (saturates at 0xFFFFFFFF) and overflow is set.
  - Records with magic 0 are pushed like any other; the scheduler does not filter.
- flush:
  - Empties the FIFO the next cycle.
  - The record currently in the serializer completes normally.
  - If in_enable coincides with flush, flush wins and the record is discarded without counting as a drop.
- FSM:
  - IDLE: out_valid=0. If FIFO is non-empty, pop the head into the shift register, set beat index 0, go to SEND. The first beat is visible the cycle after the pop.
  - SEND: out_valid=1; out_data = record bits [idx*BEAT_W +: BEAT_W], LSB beat first. Bits beyond REC_W in the final beat are zero. out_last=1 when idx==NBEATS-1.
    - On out_valid && out_ready with idx<NBEATS-1: idx++.
    - On the last beat accepted with FIFO non-empty: pop the next record, idx=0, stay in SEND. Back-to-back records have no bubble.
    - On the last beat accepted with FIFO empty: go to IDLE.
  - out_data and out_last hold stable while out_valid && !out_ready.
- drained = (state==IDLE) && FIFO empty, registered. It is low from the cycle after a push is accepted until the cycle after the final beat handshake.
- FIFO:
  - Circular buffer, pointers one bit wider than log2(DEPTH) to tell full from empty.
  - Wrap-around is silent.
  - Count range 0..DEPTH.
- Throughput: at most one record per NBEATS cycles sustained. Bursts up to DEPTH-1 regular records absorb without loss.

Decomposition:
- Shared package dse_pkg:
  - magic constants MAGIC_EMULATE=1, MAGIC_DEG=2, MAGIC_DEGDONE=3, MAGIC_FINISH=4;
  - MAGIC_W;
  - state enum {IDLE, SEND}.
- Sub-module dse_rec_fifo (parameters REC_W, DEPTH):
  - push/pop/flush;
  - count and head outputs.
  - Admission policy stays in the top module.

Test Plan:
- Single DEG record: magic 2, payload = incrementing bytes, out_ready=1 → 5 beats on consecutive cycles after a 1-cycle pop delay. Beat 4 carries bits 256..263 with the rest zero; out_last only on beat 4; drained returns to 1.
- Backpressure: same record, out_ready toggling 1,0,0,1… → beats never skipped or duplicated; out_data stable while stalled; 5 handshakes total.
- Overflow with reserve: out_ready=0, push 10 consecutive magic-2 records, then 1 magic-4 → 7 regular records queued (the head may already sit in the serializer); drop_cnt=3, overflow=1; finish is accepted and emitted last once out_ready=1.
- Back-to-back: 3 queued records, out_ready=1 → 15 beats with no valid gap; out_last on beats 4, 9 and 14.
- Flush mid-stream: 4 queued, flush during beat 2 of record 0 → record 0 completes, nothing follows; drained=1; drop_cnt unchanged.
- Async reset mid-record: assert reset between clock edges during beat 3 → out_valid=0 immediately; drop_cnt=0; a new record after release serializes from beat 0.
